// File: rtl/ov7670_capture.sv
// ---------------------------------------------------------------------------
// ov7670_capture
//
// Front end for the camera frame buffer. The raw OV7670 parallel bus is
// brought into the system clock domain, whole frames are located using
// VSYNC, and each RGB565 byte pair is reduced to one RGB332 pixel. Every
// stored pixel produces a one-cycle write strobe with a linear address
// into the write port of the dual-port frame RAM.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_capture_en   level, 1 = capture frames continuously
//   i_cam_pclk     camera pixel clock (raw pin, sampled as data)
//   i_cam_href     camera line valid (raw pin)
//   i_cam_vsync    camera frame sync, high during vertical blanking
//   i_cam_data     camera data bus (raw pin)
//   o_pixel        RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   o_w_addr       frame RAM write address
//   o_w_en         one-cycle write strobe
//   o_frame_done   one-cycle pulse when a captured frame ends
//   o_busy         high while a frame is being captured
//   o_odd_err      sticky, a line ended on an odd byte count
// ---------------------------------------------------------------------------
module ov7670_capture #(
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_capture_en,
  input  logic              i_cam_pclk,
  input  logic              i_cam_href,
  input  logic              i_cam_vsync,
  input  logic [7:0]        i_cam_data,
  output logic [7:0]        o_pixel,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic              o_w_en,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_odd_err
);

  // Counters are one value wider than the image so they can saturate at
  // IMG_W / IMG_H, which is what marks "outside the stored window".
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);

  localparam logic [XW-1:0]     IMG_W_X = XW'(IMG_W);
  localparam logic [YW-1:0]     IMG_H_Y = YW'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS_HI,
    S_WAIT_VS_LO,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // All camera pins share one 2-FF synchroniser vector so that PCLK, HREF,
  // VSYNC and DATA see identical delay and stay aligned with each other.
  logic [10:0] w_raw;
  logic [10:0] r_sync1;
  logic [10:0] r_sync2;

  logic        w_pclk_s;
  logic        w_href_s;
  logic        w_vs_s;
  logic [7:0]  w_data_s;

  logic        r_pclk_d;
  logic        r_href_d;
  logic        r_vs_d;

  logic        w_sample;
  logic        w_href_fall;
  logic        w_vs_rise;
  logic        w_vs_fall;

  logic        w_frame_start;
  logic        w_frame_end;

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_phase;
  logic [5:0]        r_b1;      // only the bits of the first byte that survive packing

  logic [7:0]        r_pixel;
  logic [ADDR_W-1:0] r_w_addr;
  logic              r_w_en;
  logic              r_frame_done;
  logic              r_odd_err;

  assign w_raw = {i_cam_pclk, i_cam_href, i_cam_vsync, i_cam_data};

  assign w_pclk_s = r_sync2[10];
  assign w_href_s = r_sync2[9];
  assign w_vs_s   = r_sync2[8];
  assign w_data_s = r_sync2[7:0];

  assign w_sample    = w_pclk_s & ~r_pclk_d;
  assign w_href_fall = r_href_d & ~w_href_s;
  assign w_vs_rise   = w_vs_s & ~r_vs_d;
  assign w_vs_fall   = r_vs_d & ~w_vs_s;

  // Synchroniser and edge-detect history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_pclk_d <= 1'b0;
      r_href_d <= 1'b0;
      r_vs_d   <= 1'b0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_pclk_d <= w_pclk_s;
      r_href_d <= w_href_s;
      r_vs_d   <= w_vs_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. Capture only begins on a VSYNC falling edge that was
  // preceded by VSYNC high while armed, so a frame is never joined midway.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_capture_en) begin
          w_state_next = S_WAIT_VS_HI;
        end
      end
      S_WAIT_VS_HI: begin
        if (w_vs_s) begin
          w_state_next = S_WAIT_VS_LO;
        end
      end
      S_WAIT_VS_LO: begin
        if (w_vs_fall) begin
          w_state_next  = S_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Dropping capture enable mid-frame only takes effect here, at the
        // end of the frame.
        if (w_vs_rise) begin
          w_frame_end  = 1'b1;
          w_state_next = i_capture_en ? S_WAIT_VS_LO : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Pixel packing, position tracking and write generation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_row_base   <= '0;
      r_phase      <= 1'b0;
      r_b1         <= '0;
      r_pixel      <= '0;
      r_w_addr     <= '0;
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      r_odd_err    <= 1'b0;
    end else begin
      r_w_en       <= 1'b0;
      r_frame_done <= w_frame_end;
      if (w_frame_start) begin
        r_x        <= '0;
        r_y        <= '0;
        r_row_base <= '0;
        r_phase    <= 1'b0;
        r_odd_err  <= 1'b0;
      end else if (r_state == S_ACTIVE) begin
        // A sample needs HREF high and a line end needs HREF low, so the two
        // branches are mutually exclusive. A line end coinciding with the
        // VSYNC rise is still processed here before the FSM leaves ACTIVE.
        if (w_sample && w_href_s) begin
          if (!r_phase) begin
            r_b1    <= {w_data_s[7:5], w_data_s[2:0]};
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if ((r_x < IMG_W_X) && (r_y < IMG_H_Y)) begin
              r_pixel  <= {r_b1, w_data_s[4:3]};
              r_w_addr <= r_row_base + ADDR_W'(r_x);
              r_w_en   <= 1'b1;
            end
            if (r_x < IMG_W_X) begin
              r_x <= r_x + XW'(1);
            end
          end
        end else if (w_href_fall) begin
          if (r_phase) begin
            r_odd_err <= 1'b1;
          end
          r_phase <= 1'b0;
          // Empty lines (no complete pixel) do not advance the row. The row
          // base is accumulated instead of computed as y*IMG_W; once y has
          // saturated the base is frozen, so it can never produce an address
          // for a row outside the window.
          if (r_x != '0) begin
            if (r_y < IMG_H_Y) begin
              r_y        <= r_y + YW'(1);
              r_row_base <= r_row_base + IMG_W_A;
            end
            r_x <= '0;
          end
        end
      end
    end
  end

  assign o_pixel      = r_pixel;
  assign o_w_addr     = r_w_addr;
  assign o_w_en       = r_w_en;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state == S_ACTIVE);
  assign o_odd_err    = r_odd_err;

endmodule

// File: tb/tb_ov7670_capture.sv
// ---------------------------------------------------------------------------
// tb_ov7670_capture
//
// Directed bench for ov7670_capture, run with a reduced 16x8 image so that
// complete frames (including the address-space boundary, 16*8 = 2^7) stay
// short. A monitor logs every write strobe and FRAME_DONE pulse; the tests
// compare the log against hand-computed addresses and pixels.
// ---------------------------------------------------------------------------
module tb_ov7670_capture;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 7;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          pclk  = 1'b0;
  logic          href  = 1'b0;
  logic          vsync = 1'b0;
  logic [7:0]    data  = 8'h00;

  logic [7:0]    pixel;
  logic [AW-1:0] waddr;
  logic          wen;
  logic          fd;
  logic          busy;
  logic          odd;

  always #5 clk = ~clk;

  ov7670_capture #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_capture_en (en),
    .i_cam_pclk   (pclk),
    .i_cam_href   (href),
    .i_cam_vsync  (vsync),
    .i_cam_data   (data),
    .o_pixel      (pixel),
    .o_w_addr     (waddr),
    .o_w_en       (wen),
    .o_frame_done (fd),
    .o_busy       (busy),
    .o_odd_err    (odd)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    pix;
  } wr_t;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] exp_pix;
  } vec_t;

  wr_t  wq[$];
  int   ea[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  logic prev_wen = 1'b0;
  logic prev_fd  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write / frame-done monitor, sampled 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (wen) begin
      chk("w_en_back_to_back", 32'(prev_wen), 32'd0);
      wq.push_back('{waddr, pixel});
      $display("write addr=%0d pixel=0x%02h", waddr, pixel);
    end
    if (fd) begin
      chk("frame_done_width", 32'(prev_fd), 32'd0);
      fd_cnt++;
      $display("frame_done at %0t", $time);
    end
    prev_wen = wen;
    prev_fd  = fd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One camera byte: PCLK low for 2 clocks with data set, then high for 2
  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk);
    data = b;
    pclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic line_end();
    @(negedge clk);
    pclk = 1'b0;
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cam_line(input int nbytes, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      cam_byte((i % 2 == 0) ? b1 : b2);
    end
    line_end();
  endtask

  task automatic vs_start();
    @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_end();
    @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input int nlines, input int nbytes);
    vs_start();
    for (int l = 0; l < nlines; l++) begin
      cam_line(nbytes, 8'hE7, 8'h18);
    end
    vs_end();
  endtask

  // Expected addresses: nlines rows of wpl writes; row short_l has short_n
  task automatic fill_ea(input int nlines, input int wpl, input int short_l, input int short_n);
    ea.delete();
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < ((l == short_l) ? short_n : wpl); x++) begin
        ea.push_back(l * W + x);
      end
    end
  endtask

  task automatic check_writes(input string name, input logic [7:0] exp_pix);
    chk({name, "_count"}, 32'(wq.size()), 32'(ea.size()));
    for (int i = 0; i < wq.size() && i < ea.size(); i++) begin
      chk({name, "_addr"}, 32'(wq[i].addr), 32'(ea[i]));
      chk({name, "_pixel"}, 32'(wq[i].pix), 32'(exp_pix));
    end
    wq.delete();
  endtask

  vec_t vecs[9];

  initial begin
    // Pixel = {b1[7:5], b1[2:0], b2[4:3]}, worked out by hand per entry
    vecs[0] = '{8'hE7, 8'h18, 8'hFF};
    vecs[1] = '{8'hA0, 8'h08, 8'hA1};
    vecs[2] = '{8'h05, 8'h00, 8'h14};
    vecs[3] = '{8'h00, 8'h00, 8'h00};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{8'h12, 8'h34, 8'h0A};
    vecs[6] = '{8'hC3, 8'h5A, 8'hCF};
    vecs[7] = '{8'h38, 8'hE0, 8'h20};
    vecs[8] = '{8'h07, 8'h10, 8'h1E};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_w_en", 32'(wen), 32'd0);
    chk("rst_w_addr", 32'(waddr), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_frame_done", 32'(fd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_odd_err", 32'(odd), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);

    // ---- full frame, constant data ----
    fd_cnt = 0;
    vs_start();
    chk("f1_busy_active", 32'(busy), 32'd1);
    for (int l = 0; l < H; l++) cam_line(2 * W, 8'hE7, 8'h18);
    vs_end();
    fill_ea(H, W, -1, 0);
    check_writes("f1", 8'hFF);
    chk("f1_frame_done", 32'(fd_cnt), 32'd1);
    chk("f1_odd_err", 32'(odd), 32'd0);
    chk("f1_busy_after", 32'(busy), 32'd0);

    // ---- table-driven pixel packing ----
    fd_cnt = 0;
    vs_start();
    @(negedge clk);
    href = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cam_byte(vecs[i].b1);
      cam_byte(vecs[i].b2);
    end
    line_end();
    vs_end();
    chk("tab_count", 32'(wq.size()), 32'd9);
    for (int i = 0; i < 9 && i < wq.size(); i++) begin
      chk("tab_addr", 32'(wq[i].addr), 32'(i));
      chk("tab_pixel", 32'(wq[i].pix), 32'(vecs[i].exp_pix));
    end
    wq.delete();
    chk("tab_frame_done", 32'(fd_cnt), 32'd1);

    // ---- W_EN latency after the phase-1 sample event ----
    vs_start();
    @(negedge clk);
    href = 1'b1;
    cam_byte(8'hE7);
    @(negedge clk);
    data = 8'h18;
    pclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    @(posedge clk); #1;
    chk("lat_edge0", 32'(wen), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge1", 32'(wen), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(wen), 32'd1);
    chk("lat_pixel", 32'(pixel), 32'hFF);
    chk("lat_addr", 32'(waddr), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", 32'(wen), 32'd0);
    chk("lat_pixel_hold", 32'(pixel), 32'hFF);
    line_end();
    vs_end();
    chk("lat_count", 32'(wq.size()), 32'd1);
    wq.delete();

    // ---- oversize frame: 20x10 pixels into a 16x8 window ----
    frame(H + 2, 2 * (W + 4));
    fill_ea(H, W, -1, 0);
    if (wq.size() > 0) chk("over_last_addr", 32'(wq[wq.size()-1].addr), 32'(W * H - 1));
    else chk("over_last_addr", 32'(wq.size()), 32'(W * H));
    check_writes("over", 8'hFF);

    // ---- odd byte count on line 3 ----
    vs_start();
    for (int l = 0; l < H; l++) begin
      cam_line((l == 3) ? 2 * W - 1 : 2 * W, 8'hE7, 8'h18);
      if (l == 2) chk("odd_before", 32'(odd), 32'd0);
      if (l == 3) chk("odd_set", 32'(odd), 32'd1);
    end
    vs_end();
    chk("odd_sticky", 32'(odd), 32'd1);
    fill_ea(H, W, 3, W - 1);
    check_writes("odd", 8'hFF);
    vs_start();
    chk("odd_cleared", 32'(odd), 32'd0);
    vs_end();

    // ---- asynchronous reset mid-frame ----
    vs_start();
    cam_line(2 * W, 8'hE7, 8'h18);
    cam_line(2 * W, 8'hE7, 8'h18);
    @(negedge clk);
    href = 1'b1;
    for (int i = 0; i < 10; i++) cam_byte((i % 2 == 0) ? 8'hE7 : 8'h18);
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_writes_before", 32'(wq.size()), 32'(2 * W + 5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_en", 32'(wen), 32'd0);
    chk("mid_rst_w_addr", 32'(waddr), 32'd0);
    chk("mid_rst_pixel", 32'(pixel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    for (int i = 10; i < 2 * W; i++) cam_byte((i % 2 == 0) ? 8'hE7 : 8'h18);
    line_end();
    for (int l = 3; l < H; l++) cam_line(2 * W, 8'hE7, 8'h18);
    chk("mid_no_writes", 32'(wq.size()), 32'd0);
    frame(2, 2 * W);
    fill_ea(2, W, -1, 0);
    check_writes("mid_restart", 8'hFF);

    // ---- capture enable dropped mid-frame ----
    fd_cnt = 0;
    vs_start();
    for (int l = 0; l < H; l++) begin
      if (l == H / 2) en = 1'b0;
      cam_line(2 * W, 8'hE7, 8'h18);
    end
    vs_end();
    fill_ea(H, W, -1, 0);
    check_writes("en_drop", 8'hFF);
    chk("en_drop_frame_done", 32'(fd_cnt), 32'd1);
    chk("en_drop_busy", 32'(busy), 32'd0);
    fd_cnt = 0;
    frame(H, 2 * W);
    chk("en_off_writes", 32'(wq.size()), 32'd0);
    chk("en_off_frame_done", 32'(fd_cnt), 32'd0);
    chk("en_off_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
